// File: rtl/uart_hex_dump.sv
// -----------------------------------------------------------------------------
// uart_hex_dump
//   Buffered byte-to-ASCII-hex formatter that sits between a UART receiver and
//   a UART transmitter. Each received byte is queued in a FIFO and then sent as
//   two hex digits followed by a separator character. After every
//   BYTES_PER_LINE bytes, CR LF is sent in place of the separator.
//
// Parameters
//   DEPTH          FIFO entries (power of two, 2..256)
//   BYTES_PER_LINE bytes per output line before CR LF (1..255)
//   LOWERCASE      1: hex letters a-f, 0: hex letters A-F
//   SEP_CHAR       character sent after each byte that does not end a line
//
// Ports
//   CLK       system clock
//   RST       asynchronous reset, active-high
//   in_valid  one-cycle strobe qualifying in_data
//   in_data   byte to dump
//   tx_busy   busy flag from the UART transmitter
//   tx_en     start strobe to the UART transmitter (held until busy is seen)
//   tx_data   character to the UART transmitter, stable while tx_en=1
//   level     current FIFO occupancy
//   overflow  sticky flag, set when an incoming byte is dropped
//   idle      1 when the FIFO is empty and the formatter is idle
// -----------------------------------------------------------------------------
module uart_hex_dump #(
  parameter int         DEPTH          = 16,
  parameter int         BYTES_PER_LINE = 8,
  parameter bit         LOWERCASE      = 1'b0,
  parameter logic [7:0] SEP_CHAR       = 8'h20
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   tx_busy,
  output logic                   tx_en,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   idle
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];
  localparam logic [7:0]  LINE_LEN   = BYTES_PER_LINE[7:0];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_SEP,
    ST_CR,
    ST_LF
  } state_t;

  // Per-character handshake phase inside every send state.
  typedef enum logic [1:0] {
    PH_LOAD,
    PH_ARM,
    PH_DRAIN
  } phase_t;

  state_t        state;
  phase_t        phase;
  logic          seen_low;
  logic [7:0]    byte_r;
  logic [7:0]    line_cnt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_ok;

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = (LOWERCASE ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
    end
    return c;
  endfunction

  function automatic logic [7:0] char_of(input state_t s, input logic [7:0] b);
    logic [7:0] c;
    case (s)
      ST_HI:   c = hex_digit(b[7:4]);
      ST_LO:   c = hex_digit(b[3:0]);
      ST_SEP:  c = SEP_CHAR;
      ST_CR:   c = 8'h0D;
      ST_LF:   c = 8'h0A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // A pop frees a slot in the same cycle, so a write to a full FIFO is still
  // accepted when it coincides with a pop.
  assign full  = (level == FULL_LEVEL);
  assign pop   = (state == ST_IDLE) && (level != '0);
  assign wr_ok = in_valid && (!full || pop);
  assign idle  = (state == ST_IDLE) && (level == '0);

  // FIFO storage is data only and needs no reset.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (in_valid && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (wr_ok && !pop) begin
        level <= level + 1'b1;
      end else if (!wr_ok && pop) begin
        level <= level - 1'b1;
      end
    end
  end

  // Formatter FSM. Every send state runs LOAD -> ARM -> DRAIN:
  //   LOAD  registers the character and raises tx_en (one cycle after entry),
  //   ARM   holds tx_en until a rising busy is seen; seen_low makes sure a
  //         busy that was already high on entry is first seen low, so a
  //         transmission still in progress is never mistaken for ours,
  //   DRAIN drops tx_en and waits for busy to fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      phase    <= PH_LOAD;
      seen_low <= 1'b0;
      byte_r   <= '0;
      line_cnt <= '0;
      tx_en    <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            byte_r <= mem[rd_ptr];
            state  <= ST_HI;
            phase  <= PH_LOAD;
          end
        end
        default: begin
          case (phase)
            PH_LOAD: begin
              tx_data  <= char_of(state, byte_r);
              tx_en    <= 1'b1;
              seen_low <= 1'b0;
              phase    <= PH_ARM;
            end
            PH_ARM: begin
              if (!tx_busy) begin
                seen_low <= 1'b1;
              end else if (seen_low) begin
                tx_en <= 1'b0;
                phase <= PH_DRAIN;
              end
            end
            PH_DRAIN: begin
              if (!tx_busy) begin
                phase <= PH_LOAD;
                case (state)
                  ST_HI: state <= ST_LO;
                  ST_LO: begin
                    // Line breaks depend only on the byte count, not on gaps.
                    if (line_cnt + 8'd1 == LINE_LEN) begin
                      line_cnt <= '0;
                      state    <= ST_CR;
                    end else begin
                      line_cnt <= line_cnt + 8'd1;
                      state    <= ST_SEP;
                    end
                  end
                  ST_CR:   state <= ST_LF;
                  default: state <= ST_IDLE;
                endcase
              end
            end
            default: phase <= PH_LOAD;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_dump.sv
// -----------------------------------------------------------------------------
// tb_uart_hex_dump
//   Directed bench for uart_hex_dump. Two instances: dut_a (upper case,
//   DEPTH=16, 8 bytes per line) and dut_b (lower case). Each has a UART
//   transmitter model whose busy rises one clock after tx_en and stays high
//   for 20 clocks; every accepted character is appended to a queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_hex_dump;

  logic       clk;
  logic       rst;
  logic       mdl_clr;

  logic       in_valid_a, in_valid_b;
  logic [7:0] in_data_a, in_data_b;
  logic       busy_a, busy_b;
  logic       tx_en_a, tx_en_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic [4:0] level_a, level_b;
  logic       overflow_a, overflow_b;
  logic       idle_a, idle_b;

  int         cnt_a, cnt_b;
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  logic [7:0] exp_q[$];
  int         mdl_line;

  int checks;
  int failures;

  uart_hex_dump #(.DEPTH(16), .BYTES_PER_LINE(8), .LOWERCASE(1'b0), .SEP_CHAR(8'h20)) dut_a (
    .CLK(clk), .RST(rst), .in_valid(in_valid_a), .in_data(in_data_a), .tx_busy(busy_a),
    .tx_en(tx_en_a), .tx_data(tx_data_a), .level(level_a), .overflow(overflow_a), .idle(idle_a)
  );

  uart_hex_dump #(.DEPTH(16), .BYTES_PER_LINE(8), .LOWERCASE(1'b1), .SEP_CHAR(8'h20)) dut_b (
    .CLK(clk), .RST(rst), .in_valid(in_valid_b), .in_data(in_data_b), .tx_busy(busy_b),
    .tx_en(tx_en_b), .tx_data(tx_data_b), .level(level_b), .overflow(overflow_b), .idle(idle_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter models; deliberately not cleared by the DUT reset.
  always @(posedge clk) begin
    if (mdl_clr) begin
      busy_a <= 1'b0;
      cnt_a  <= 0;
    end else if (busy_a) begin
      if (cnt_a == 1) busy_a <= 1'b0;
      cnt_a <= cnt_a - 1;
    end else if (tx_en_a) begin
      busy_a <= 1'b1;
      cnt_a  <= 20;
      rx_a.push_back(tx_data_a);
    end
  end

  always @(posedge clk) begin
    if (mdl_clr) begin
      busy_b <= 1'b0;
      cnt_b  <= 0;
    end else if (busy_b) begin
      if (cnt_b == 1) busy_b <= 1'b0;
      cnt_b <= cnt_b - 1;
    end else if (tx_en_b) begin
      busy_b <= 1'b1;
      cnt_b  <= 20;
      rx_b.push_back(tx_data_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rx(input bit sel, input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (((sel ? rx_b.size() : rx_a.size()) < n) && (t < budget)) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rx_timeout"}, 32'(((sel ? rx_b.size() : rx_a.size()) >= n) ? 1 : 0), 32'd1);
  endtask

  task automatic wait_idle(input bit sel, input int budget, input string tag);
    int t;
    t = 0;
    while (!(sel ? idle_b : idle_a) && (t < budget)) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_idle"}, 32'(sel ? idle_b : idle_a), 32'd1);
  endtask

  task automatic load_str(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Reference formatter for long streams: two upper-case digits, then a
  // space or CR LF after every eighth byte.
  task automatic expect_byte(input logic [7:0] b);
    string hexu;
    hexu = "0123456789ABCDEF";
    exp_q.push_back(hexu[int'(b[7:4])]);
    exp_q.push_back(hexu[int'(b[3:0])]);
    mdl_line++;
    if (mdl_line == 8) begin
      mdl_line = 0;
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end else begin
      exp_q.push_back(8'h20);
    end
  endtask

  task automatic compare_rx(input bit sel, input int base, input string tag);
    int n;
    logic [7:0] got;
    n = sel ? rx_b.size() : rx_a.size();
    check({tag, "_count"}, 32'(n - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 8'h00;
      if (base + i < n) got = sel ? rx_b[base + i] : rx_a[base + i];
      check($sformatf("%s_ch%0d", tag, i), {24'h0, got}, {24'h0, exp_q[i]});
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    in_valid_a = 1'b1;
    in_data_a  = b;
    @(negedge clk);
    in_valid_a = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    checks     = 0;
    failures   = 0;
    mdl_line   = 0;
    rst        = 1'b1;
    mdl_clr    = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_data_a  = 8'h00;
    in_data_b  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx_en", 32'(tx_en_a), 32'd0);
    check("rst_tx_data", 32'(tx_data_a), 32'd0);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_overflow", 32'(overflow_a), 32'd0);
    check("rst_idle", 32'(idle_a), 32'd1);
    rst     = 1'b0;
    mdl_clr = 1'b0;
    @(negedge clk);

    // Test 1: single byte A5 with latency checks
    base = rx_a.size();
    send_a(8'hA5);
    check("t1_level_wr", 32'(level_a), 32'd1);
    check("t1_idle_wr", 32'(idle_a), 32'd0);
    check("t1_tx_en_wr", 32'(tx_en_a), 32'd0);
    @(negedge clk);
    check("t1_level_pop", 32'(level_a), 32'd0);
    check("t1_idle_pop", 32'(idle_a), 32'd0);
    check("t1_tx_en_pop", 32'(tx_en_a), 32'd0);
    @(negedge clk);
    check("t1_tx_en_rise", 32'(tx_en_a), 32'd1);
    check("t1_tx_data_hi", 32'(tx_data_a), 32'h41);
    wait_rx(1'b0, base + 3, 200, "t1");
    wait_idle(1'b0, 100, "t1");
    load_str("A5 ");
    compare_rx(1'b0, base, "t1");

    // Test 2: lower-case instance, bytes 3F and AB
    base = rx_b.size();
    in_valid_b = 1'b1;
    in_data_b  = 8'h3F;
    @(negedge clk);
    in_data_b  = 8'hAB;
    @(negedge clk);
    in_valid_b = 1'b0;
    wait_rx(1'b1, base + 6, 400, "t2");
    wait_idle(1'b1, 100, "t2");
    load_str("3f ab ");
    compare_rx(1'b1, base, "t2");

    // Test 3: fresh line, burst 00..07 ends with CR LF and no separator
    pulse_rst();
    base = rx_a.size();
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 8'(i);
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    wait_rx(1'b0, base + 25, 1200, "t3");
    wait_idle(1'b0, 100, "t3");
    load_str("00 01 02 03 04 05 06 07");
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    compare_rx(1'b0, base, "t3");

    // Test 4: 20 back-to-back strobes; 17 stored, 18th dropped
    base = rx_a.size();
    for (int i = 0; i < 20; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 8'(8'h10 + i);
      @(negedge clk);
      if (i == 16) begin
        check("t4_level_full", 32'(level_a), 32'd16);
        check("t4_ovf_before", 32'(overflow_a), 32'd0);
      end
      if (i == 17) check("t4_ovf_set", 32'(overflow_a), 32'd1);
    end
    in_valid_a = 1'b0;
    exp_q.delete();
    mdl_line = 0;
    for (int i = 0; i < 17; i++) expect_byte(8'(8'h10 + i));
    wait_rx(1'b0, base + exp_q.size(), 3000, "t4");
    wait_idle(1'b0, 100, "t4");
    compare_rx(1'b0, base, "t4");
    check("t4_ovf_sticky", 32'(overflow_a), 32'd1);

    // Test 6: write coinciding with a pop while full is accepted
    pulse_rst();
    check("t6_ovf_cleared", 32'(overflow_a), 32'd0);
    base = rx_a.size();
    exp_q.delete();
    mdl_line = 0;
    for (int i = 0; i < 17; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = (i == 0) ? 8'h55 : 8'(8'h5F + i);
      expect_byte(in_data_a);
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    check("t6_level_full", 32'(level_a), 32'd16);
    check("t6_ovf_fill", 32'(overflow_a), 32'd0);
    wait_rx(1'b0, base + 3, 200, "t6_sep");
    begin
      int t;
      t = 0;
      while (busy_a && t < 40) begin
        @(negedge clk);
        t++;
      end
      check("t6_busy_fall", 32'(busy_a), 32'd0);
    end
    @(negedge clk);
    check("t6_level_prepop", 32'(level_a), 32'd16);
    check("t6_idle_prepop", 32'(idle_a), 32'd0);
    in_valid_a = 1'b1;
    in_data_a  = 8'h77;
    expect_byte(8'h77);
    @(negedge clk);
    in_valid_a = 1'b0;
    check("t6_level_same", 32'(level_a), 32'd16);
    check("t6_ovf_clear", 32'(overflow_a), 32'd0);
    wait_rx(1'b0, base + exp_q.size(), 3500, "t6");
    wait_idle(1'b0, 100, "t6");
    compare_rx(1'b0, base, "t6");

    // Test 5: reset during the LO digit, then a full line from count 0
    base = rx_a.size();
    send_a(8'h3C);
    wait_rx(1'b0, base + 2, 200, "t5_lo");
    check("t5_tx_en_pre", 32'(tx_en_a), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_tx_en_rst", 32'(tx_en_a), 32'd0);
    check("t5_tx_data_rst", 32'(tx_data_a), 32'd0);
    check("t5_level_rst", 32'(level_a), 32'd0);
    check("t5_idle_rst", 32'(idle_a), 32'd1);
    load_str("3C");
    compare_rx(1'b0, base, "t5_pre");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = rx_a.size();
    exp_q.delete();
    mdl_line = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1'b1;
      in_data_a  = 8'(8'h90 + i);
      expect_byte(in_data_a);
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    wait_rx(1'b0, base + exp_q.size(), 1500, "t5");
    wait_idle(1'b0, 100, "t5");
    compare_rx(1'b0, base, "t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
